// File: rtl/keypad_letter_decoder.sv
// keypad_letter_decoder: multi-tap keypad to ASCII letter decoder; optional idle auto-commit under KEYPAD_DECODE_TIMEOUT_EN
module keypad_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cur_key,
  input  logic       strobe,
  output logic [7:0] pending_letter,
  output logic       pending_valid,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       clear
);
  typedef enum logic {IDLE, TAP} state_t;
  state_t     state;
  logic [3:0] pend_digit;
  logic [1:0] tap_idx;
  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [1:0] enc(input logic [3:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction
  function automatic logic [7:0] base_of(input logic [3:0] d);
    return 8'd59 + 8'd3 * {4'd0, d} + {7'd0, d >= 4'd8};
  endfunction
  logic [3:0] row, col;
  logic [1:0] r_idx, c_idx, nidx;
  logic [3:0] digit;
  logic       key_ok, is_letter, is_hash, is_star, same_key, pend_wrap;
  logic [7:0] key_base, pend_base;
  assign row       = cur_key[7:4];
  assign col       = cur_key[3:0];
  assign r_idx     = enc(row);
  assign c_idx     = enc(col);
  assign key_ok    = strobe && one_hot(row) && one_hot(col);
  assign is_letter = key_ok && r_idx != 2'd3 && c_idx != 2'd3 && !(r_idx == 2'd0 && c_idx == 2'd0);
  assign is_hash   = key_ok && row[3] && col[2];
  assign is_star   = key_ok && row[3] && col[0];
  assign digit     = {2'd0, r_idx} * 4'd3 + {2'd0, c_idx} + 4'd1;
  assign key_base  = base_of(digit);
  assign pend_base = base_of(pend_digit);
  assign same_key  = digit == pend_digit;
  assign pend_wrap = tap_idx == ((pend_digit == 4'd7 || pend_digit == 4'd9) ? 2'd3 : 2'd2);
  assign nidx      = pend_wrap ? 2'd0 : tap_idx + 2'd1;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
`ifdef KEYPAD_DECODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;
  logic          expired;
  assign expired = timer == TW'(TIMEOUT_CYCLES - 1);
`else
  logic expired;
  assign expired = 1'b0;
`endif
  // tap sequencing: load/advance the pending letter, commit on #, new key or idle timeout, discard on *
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pend_digit     <= 4'd0;
      tap_idx        <= 2'd0;
      pending_letter <= 8'h00;
      pending_valid  <= 1'b0;
      letter         <= 8'h00;
      letter_valid   <= 1'b0;
      clear          <= 1'b0;
`ifdef KEYPAD_DECODE_TIMEOUT_EN
      timer          <= '0;
`endif
    end else begin
      letter_valid <= 1'b0;
      clear        <= 1'b0;
`ifdef KEYPAD_DECODE_TIMEOUT_EN
      if (state == TAP && timer != '1) timer <= timer + 1'b1;
      if (is_letter) timer <= '0;
`endif
      if (state == IDLE) begin
        if (is_letter) begin
          state          <= TAP;
          pend_digit     <= digit;
          tap_idx        <= 2'd0;
          pending_letter <= key_base;
          pending_valid  <= 1'b1;
        end
      end else if (is_letter && same_key) begin
        tap_idx        <= nidx;
        pending_letter <= pend_base + {6'd0, nidx};
      end else if (is_letter) begin
        letter         <= pending_letter;
        letter_valid   <= 1'b1;
        pend_digit     <= digit;
        tap_idx        <= 2'd0;
        pending_letter <= key_base;
      end else if (is_hash || is_star || expired) begin
        letter         <= is_star ? letter : pending_letter;
        letter_valid   <= !is_star;
        clear          <= is_star;
        state          <= IDLE;
        tap_idx        <= 2'd0;
        pending_letter <= 8'h00;
        pending_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keypad_letter_decoder.sv
// tb_keypad_letter_decoder: scoreboard bench for the multi-tap letter decoder
module tb_keypad_letter_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cur_key = 8'h00;
  logic       strobe = 1'b0;
  logic [7:0] pending_letter, letter;
  logic       pending_valid, letter_valid, clear;
  int         checks = 0;
  int         errors = 0;
  int         clears_seen = 0;
  int         clears_exp = 0;
  logic [7:0] exp_q[$];
  keypad_letter_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cur_key(cur_key), .strobe(strobe),
    .pending_letter(pending_letter), .pending_valid(pending_valid),
    .letter(letter), .letter_valid(letter_valid), .clear(clear)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tap(input logic [7:0] k);
    @(negedge clk);
    cur_key = k;
    strobe  = 1'b1;
    @(negedge clk);
    strobe  = 1'b0;
    cur_key = 8'h00;
  endtask
  // monitor: every committed letter must match the oldest expected one
  always @(negedge clk) begin
    if (!rst) begin
      if (letter_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit: got letter %0h with nothing expected", letter);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (letter !== e) begin
            errors++;
            $display("FAIL commit_letter: got %0h expected %0h", letter, e);
          end
        end
      end
      if (clear) clears_seen++;
    end
  end
  initial begin
    logic [7:0] btb[5];
    btb = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h42};
    repeat (2) @(negedge clk);
    chk("rst_pending", {24'd0, pending_letter}, 32'h00);
    chk("rst_pvalid", {31'd0, pending_valid}, 32'd0);
    chk("rst_letter", {24'd0, letter}, 32'h00);
    chk("rst_lvalid", {31'd0, letter_valid}, 32'd0);
    chk("rst_clear", {31'd0, clear}, 32'd0);
    rst = 1'b0;
    tap(8'h12);
    chk("t2_pending_a", {24'd0, pending_letter}, 32'h41);
    chk("t2_pvalid", {31'd0, pending_valid}, 32'd1);
    tap(8'h12);
    chk("t2_pending_b", {24'd0, pending_letter}, 32'h42);
    exp_q.push_back(8'h42);
    tap(8'h84);
    chk("hash_pvalid", {31'd0, pending_valid}, 32'd0);
    chk("hash_pending", {24'd0, pending_letter}, 32'h00);
    for (int i = 0; i < 5; i++) begin
      automatic logic [7:0] pq[5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
      tap(8'h41);
      chk("t7_cycle", {24'd0, pending_letter}, {24'd0, pq[i]});
    end
    exp_q.push_back(8'h50);
    tap(8'h84);
    tap(8'h12);
    exp_q.push_back(8'h41);
    tap(8'h14);
    chk("switch_pending", {24'd0, pending_letter}, 32'h44);
    chk("switch_pvalid", {31'd0, pending_valid}, 32'd1);
    exp_q.push_back(8'h44);
    tap(8'h84);
    tap(8'h12);
    clears_exp++;
    tap(8'h81);
    chk("star_pvalid", {31'd0, pending_valid}, 32'd0);
    repeat (3) @(negedge clk);
    tap(8'h12);
    tap(8'h33);
    tap(8'h00);
    tap(8'h11);
    chk("invalid_pending", {24'd0, pending_letter}, 32'h41);
    chk("invalid_pvalid", {31'd0, pending_valid}, 32'd1);
    exp_q.push_back(8'h41);
    tap(8'h84);
    tap(8'h84);
    tap(8'h81);
    chk("idle_ctrl_pvalid", {31'd0, pending_valid}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cur_key = btb[i];
      strobe  = 1'b1;
      if (i == 4) exp_q.push_back(8'h5A);
      @(negedge clk);
    end
    strobe = 1'b0;
    chk("btb_pending", {24'd0, pending_letter}, 32'h54);
    exp_q.push_back(8'h54);
    tap(8'h84);
    tap(8'h14);
    tap(8'h14);
    chk("pre_rst_pending", {24'd0, pending_letter}, 32'h45);
    rst = 1'b1;
    #1;
    chk("async_rst_pending", {24'd0, pending_letter}, 32'h00);
    chk("async_rst_pvalid", {31'd0, pending_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tap(8'h84);
    chk("post_rst_letter", {24'd0, letter}, 32'h00);
`ifdef KEYPAD_DECODE_TIMEOUT_EN
    tap(8'h12);
    exp_q.push_back(8'h41);
    repeat (15) @(negedge clk);
    chk("to_not_yet", {31'd0, letter_valid}, 32'd0);
    @(negedge clk);
    chk("to_pvalid", {31'd0, pending_valid}, 32'd0);
    tap(8'h12);
    repeat (14) @(negedge clk);
    tap(8'h12);
    chk("to_race_pending", {24'd0, pending_letter}, 32'h42);
    chk("to_race_pvalid", {31'd0, pending_valid}, 32'd1);
    exp_q.push_back(8'h42);
    tap(8'h84);
`else
    tap(8'h12);
    repeat (40) @(negedge clk);
    chk("no_to_pending", {24'd0, pending_letter}, 32'h41);
    chk("no_to_pvalid", {31'd0, pending_valid}, 32'd1);
    exp_q.push_back(8'h41);
    tap(8'h84);
`endif
    repeat (3) @(negedge clk);
    chk("commits_drained", exp_q.size(), 32'd0);
    chk("clear_count", clears_seen, clears_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_letter_decoder.md
# keypad_letter_decoder

Multi-tap (phone-style) letter decoder for the Hangman keypad path. It consumes the scanned key code and one-cycle key strobe produced by the keypad scanning front end. It turns repeated presses of digit keys 2–9 into uppercase ASCII letters, and emits one committed guess letter per confirmation for the game/transmit logic.

## Interface
- TIMEOUT_CYCLES, 10_000_000: idle cycles after the last tap before the pending letter auto-commits (only with the macro defined); minimum 2.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cur_key  input  8  {row[3:0], col[3:0]}; each nibble is one-hot; bit index = row/column number.
- strobe  input  1  one-cycle pulse; cur_key is valid in the same cycle.
- pending_letter  output  8  ASCII of the letter currently being selected; 8'h00 when none.
- pending_valid  output  1  high while a letter is being selected (state TAP).
- letter  output  8  last committed ASCII letter; holds until the next commit.
- letter_valid  output  1  one-cycle pulse on each commit.
- clear  output  1  one-cycle pulse when '*' discards a pending letter.

## Operation
- Key map, row/column indices:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- Letter groups:
  - 2=ABC, 3=DEF, 4=GHI, 5=JKL, 6=MNO, 7=PQRS, 8=TUV, 9=WXYZ.
  - Group size is 3, except 4 for keys 7 and 9.
- Valid strobe: both nibbles of cur_key are exactly one-hot. A strobe with a zero or multi-hot nibble is ignored with no state change, as are keys 1, 0, A, B, C and D.
- pending_letter = group base ASCII + tap_idx.
- State machine, two states:
  - IDLE:
    - Letter key: pend_key ← key, tap_idx ← 0, timer ← 0, go to TAP.
    - '#' or '*': ignored.
  - TAP, letter key equal to pend_key: tap_idx ← (tap_idx+1) mod group size; timer ← 0.
  - TAP, different letter key:
    - Commit the current pending letter (letter ← pending_letter, letter_valid pulse).
    - In the same cycle load the new key: tap_idx ← 0, timer ← 0, stay in TAP.
  - TAP, '#': commit, go to IDLE.
  - TAP, '*': pulse clear, no commit, go to IDLE.
  - TAP, timeout (macro only): commit, go to IDLE.
- Timer: counts clk cycles in TAP with no valid strobe. Width is $clog2(TIMEOUT_CYCLES); it saturates, never wraps.

## Timing
- Reset values:
  - State IDLE.
  - pending_letter 8'h00, pending_valid 0.
  - letter 8'h00, letter_valid 0, clear 0.
  - tap_idx 0, timer 0.
- All outputs are registered. A response to a strobe in cycle N is visible in cycle N+1.
- letter_valid and clear are high for exactly one cycle. Back-to-back strobes in consecutive cycles are each processed.
- Timeout commit: letter_valid rises TIMEOUT_CYCLES cycles after the cycle following the last accepted tap.
- Strobe and timeout expiry in the same cycle: the strobe has priority. Timeout is suppressed and the strobe is handled as in TAP.
- rst asserted mid-selection: pending letter discarded immediately (asynchronously), and no letter_valid is produced.
- strobe is a pulse. A held strobe is treated as one tap per high cycle, and the upstream front end guarantees single-cycle pulses.

## Configuration
- KEYPAD_DECODE_TIMEOUT_EN:
  - Defined: the timer is compiled in, and a pending letter auto-commits after TIMEOUT_CYCLES idle cycles.
  - Undefined: no timer logic; TIMEOUT_CYCLES is unused; commits happen only on '#' or on a different letter key.

## Test plan
- Taps '2','2' then '#': strobes at cur_key 8'h12, 8'h12, 8'h84 → pending_letter 8'h41, then 8'h42; after '#', letter=8'h42 ('B'), one letter_valid pulse, pending_valid=0.
- Taps '7' ×5 (8'h41) then '#': pending cycles P,Q,R,S and wraps to P → letter=8'h50.
- Taps '2' then '3' (8'h12, 8'h14): letter_valid with letter=8'h41 in the cycle after the '3' strobe; pending_letter=8'h44 ('D'), pending_valid stays 1.
- Tap '2' then '*' (8'h81): clear pulses once; letter_valid never asserts; state IDLE.
- Macro defined, TIMEOUT_CYCLES=16: tap '2' then idle → letter=8'h41 after 16 cycles. A second '2' strobe landing on the expiry cycle instead yields pending 'B' and no commit. Invalid codes 8'h33 and 8'h00 cause no output change.
- rst pulse while pending 'E': all outputs return to reset values; a following '#' produces no letter_valid.
